// File: rtl/clb_arith_pkg.sv
// Shared definitions for the CLB arithmetic blocks: sequencer states,
// counter sizing and the slice-offset helper.
package clb_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // ceil(log2(n)), never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = $clog2(n);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    localparam int unsigned DEF_BEATS = 32'd4;
    localparam int unsigned CNT_W     = cnt_width(DEF_BEATS);

    // Bit offset of slice idx inside a word made of slice_w-bit slices
    function automatic int unsigned slice_base(input int unsigned idx, input int unsigned slice_w);
        return idx * slice_w;
    endfunction

endpackage

// File: rtl/carry_chain.sv
// One CLB-sized ripple carry chain: a carry mux per bit selected by propagate,
// with the sum formed as P ^ carry.
module carry_chain #(
    parameter int unsigned INPUTS = 4
) (
    input  logic [INPUTS-1:0] p_i,
    input  logic [INPUTS-1:0] g_i,
    input  logic              ci_i,
    output logic [INPUTS-1:0] s_o,
    output logic              co_o,
    output logic              cmsb_o
);

    logic [INPUTS:0] c_s;

    // Mux chain: propagate passes the incoming carry, otherwise generate decides
    always_comb begin
        c_s[0] = ci_i;
        for (int i = 0; i < int'(INPUTS); i++) begin
            if (p_i[i]) begin
                c_s[i+1] = c_s[i];
            end else begin
                c_s[i+1] = g_i[i];
            end
        end
    end

    assign s_o    = p_i ^ c_s[INPUTS-1:0];
    assign co_o   = c_s[INPUTS];
    assign cmsb_o = c_s[INPUTS-1];

endmodule

// File: rtl/carry_chain_seq_adder.sv
// Wide add/subtract sequencer: streams WIDTH-bit operands through one
// INPUTS-bit carry_chain, LSB slice first, with the carry held between beats.
module carry_chain_seq_adder
    import clb_arith_pkg::*;
#(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned WIDTH  = INPUTS * BEATS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned      CW       = cnt_width(BEATS);
    localparam int unsigned      BW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(BEATS - 32'd1);

    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [BW-1:0]     base_s;
    logic [INPUTS-1:0] p_s, g_s, s_s;
    logic              co_s, cmsb_s;

    assign base_s = BW'(slice_base(32'(cnt_q), INPUTS));
    assign p_s    = a_q[base_s +: INPUTS] ^ b_q[base_s +: INPUTS];
    assign g_s    = a_q[base_s +: INPUTS] & b_q[base_s +: INPUTS];

    carry_chain #(
        .INPUTS (INPUTS)
    ) u_chain (
        .p_i    (p_s),
        .g_i    (g_s),
        .ci_i   (carry_q),
        .s_o    (s_s),
        .co_o   (co_s),
        .cmsb_o (cmsb_s)
    );

    // Next-state, datapath updates and registered handshake outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1; the +1 rides in on the carry register
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[base_s +: INPUTS] = s_s;
                carry_d                 = co_s;
                if (cnt_q == LAST_CNT) begin
                    cout_d  = co_s;
                    ovf_d   = cmsb_s ^ co_s;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_carry_chain_seq_adder.sv
// Directed bench for carry_chain_seq_adder (INPUTS=4, BEATS=4, WIDTH=16).
module tb_carry_chain_seq_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    carry_chain_seq_adder #(
        .INPUTS (4),
        .BEATS  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, measure latency, return with DONE outputs visible (not yet consumed)
    task automatic issue_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            if (!out_valid) lat++;
        end
        if (!out_valid) lat = 99;
        @(negedge clk);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_cout", {31'd0, out_cout}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue_and_wait(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
            check($sformatf("v%0d_latency", i), lat, 32'd4);
            check($sformatf("v%0d_sum", i), {16'd0, out_sum}, {16'd0, vecs[i].exp_sum});
            check($sformatf("v%0d_cout", i), {31'd0, out_cout}, {31'd0, vecs[i].exp_cout});
            check($sformatf("v%0d_ovf", i), {31'd0, out_ovf}, {31'd0, vecs[i].exp_ovf});
            consume();
        end

        // Backpressure plus in_valid pulses during RUN and DONE
        @(negedge clk);
        in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_sub = 1'b1;
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_reached_done", {31'd0, out_valid}, 32'd1);
        held = 16'h3333;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_a = 16'h0F0F; in_b = 16'hF0F0;
            @(negedge clk);
            check($sformatf("bp%0d_sum", k), {16'd0, out_sum}, {16'd0, held});
            check($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("bp_cout", {31'd0, out_cout}, 32'd0);
        consume();
        repeat (2) @(negedge clk);
        check("no_queued_op", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of RUN
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h1111; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_sum", {16'd0, out_sum}, 32'd0);
        repeat (6) @(negedge clk);
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        issue_and_wait(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        check("post_rst_latency", lat, 32'd4);
        check("post_rst_sum", {16'd0, out_sum}, 32'h0007);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/carry_chain_seq_adder.md
# carry_chain_seq_adder

Multi-cycle wide adder/subtractor sequencer that time-shares one narrow `carry_chain` slice across a wide operand. Accepts WIDTH-bit operands over a valid/ready handshake and feeds them through the chain one INPUTS-bit slice per cycle, least-significant slice first, with the carry held in a register between beats. It lets a CLB-sized carry chain serve arithmetic wider than one cluster, and presents the result and flags on a held output handshake.

## Interface
- `INPUTS`, 4: carry chain slice width (bits per beat).
- `BEATS`, 4: slices per operation; ≥1.
- `WIDTH`, INPUTS*BEATS: derived operand width; not overridden independently.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operand request.
- `in_ready` output 1: block can accept operands.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_sub` input 1: 1 = compute A − B, 0 = A + B.
- `in_cin` input 1: carry-in for add; ignored when `in_sub`=1.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes result.
- `out_sum` output WIDTH: result.
- `out_cout` output 1: carry out of MSB (for sub: 1 = no borrow).
- `out_ovf` output 1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch A, B' = `in_sub` ? ~B : B, carry register = `in_sub` ? 1 : `in_cin`, beat counter = 0, go to RUN.
- RUN: `in_ready`=0. Drive chain P = A[slice]^B'[slice], G = A[slice]&B'[slice], Ci = carry register; slice = bits [cnt*INPUTS +: INPUTS]. Write S into sum register slice; carry register ← Co; cnt++. At cnt==BEATS-1, also capture ovf = Ci_msb ^ Co of the final beat, then go to DONE.
- DONE: `out_valid`=1; `out_sum`/`out_cout`/`out_ovf` held stable. On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; no operand is queued.
- `out_ready` outside DONE has no effect.
- Beat counter width: clog2(BEATS), minimum 1 bit. It never exceeds BEATS-1; no wrap is exposed.
- BEATS=1: RUN lasts one cycle.
- Reset (any state, including mid-RUN): state = IDLE, cnt = 0, carry = 0, sum = 0, flags = 0. The in-flight operation is discarded and no result is produced.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0.
- Accept at edge T (`in_valid` & `in_ready`). RUN occupies cycles T+1..T+BEATS. `out_valid` rises after edge T+BEATS. Latency is BEATS cycles from accept to valid.
- Earliest next accept: the cycle after the DONE handshake. Maximum throughput is one operation per BEATS+2 cycles.
- Outputs are registered; no combinational path from inputs to `out_*` or `in_ready`.
- The chain's combinational path is a single slice: INPUTS mux stages.

## Structure
- Shared package `clb_arith_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - the localparam for counter width;
  - the slice-select helper.
- Sub-module: one instance of the existing `carry_chain` with `INPUTS` passed through. The sequencer adds no generate/propagate logic beyond P/G formation.
- Everything else (FSM, counter, operand/sum/carry registers) lives in this module.

## Test plan
- Add: A=0x00FF, B=0x0001, cin=0, INPUTS=4, BEATS=4 → `out_sum`=0x0100, `out_cout`=0, `out_ovf`=0; `out_valid` exactly 4 cycles after accept.
- Wrap: A=0xFFFF, B=0x0001 add → `out_sum`=0x0000, `out_cout`=1, `out_ovf`=0. Carry-in: A=0x0000, B=0x0000, cin=1 → 0x0001.
- Subtract: A=0x0005, B=0x0007, sub=1 → `out_sum`=0xFFFE, `out_cout`=0, `out_ovf`=0. Also A=0x8000, B=0x0001, sub=1 → 0x7FFF, `out_ovf`=1.
- Signed overflow: A=0x7FFF, B=0x0001 add → `out_sum`=0x8000, `out_cout`=0, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable and `in_ready`=0 throughout. Pulse `in_valid` with new operands during RUN/DONE → ignored; result unchanged.
- Reset mid-RUN: assert `rst_n`=0 for one cycle at beat 2 → next cycle `in_ready`=1, `out_valid`=0, `out_sum`=0. A following add 0x0003+0x0004 yields 0x0007.
